// File: rtl/riscv_data_ram_if.sv
// Request/response bus of the byte-lane data RAM.
// Ports (through the modports):
//   req_valid/req_ready  request handshake (ready high only once the RAM is ready)
//   req_we               1 store, 0 load
//   req_addr             byte address
//   req_size             0 byte, 1 half, 2 word, 3 dword
//   req_unsigned         loads: 1 zero-extend, 0 sign-extend
//   req_wdata            right-aligned store data
//   rsp_valid            one-cycle pulse, one cycle after accept
//   rsp_rdata            extended load data (0 for stores and errors)
//   rsp_err              misaligned or illegal-size access
interface riscv_data_ram_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/riscv_data_ram.sv
// Byte-lane data memory for the RISC-V datapath.
// Decodes access size and byte offset into per-lane write enables, zero- or
// sign-extends loads, flags misaligned / illegal-size accesses and clears the
// array after reset with an init sequencer.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   bus          riscv_data_ram_if slave (request / response)
//   init_done_o  high once the array clear has finished

// One byte lane: DEPTH x 8 array with a registered (synchronous) read.
module riscv_data_ram_lane #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Single port: write and read are never enabled in the same cycle, so a
    // store on cycle t is visible to a load on cycle t+1.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module riscv_data_ram #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    riscv_data_ram_if.slave  bus,
    output logic             init_done_o
);
    localparam int LANES  = DATA_W / 8;
    localparam int OFF    = $clog2(LANES);
    localparam int WIDX_W = ADDR_W - OFF;
    localparam int DEPTH  = 1 << WIDX_W;

    typedef enum logic [0:0] {S_INIT, S_READY} state_e;

    state_e state_q, state_d;

    logic [WIDX_W-1:0] init_cnt_q;
    logic              init_done_q;
    logic              init_last;

    // FSM outputs
    logic req_ready;
    logic init_wr;

    // Request decode
    logic              accept;
    logic [OFF-1:0]    off;
    logic [WIDX_W-1:0] widx;
    logic [3:0]        nbytes;
    logic              req_err;
    logic [LANES-1:0]  lane_mask;
    logic [DATA_W-1:0] wdata_sh;

    // Lane controls
    logic [LANES-1:0]      lane_we;
    logic                  lane_re;
    logic [WIDX_W-1:0]     lane_addr;
    logic [LANES-1:0][7:0] lane_wdata;
    logic [LANES-1:0][7:0] lane_rdata;

    // Response-stage registers: captured at accept, held otherwise, so the
    // response outputs keep their last value while rsp_valid is low.
    logic           rsp_valid_q;
    logic           rsp_err_q;
    logic           rsp_load_q;
    logic [OFF-1:0] off_q;
    logic [1:0]     size_q;
    logic           uns_q;

    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_ext;

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= (INIT_CLEAR != 0) ? S_INIT : S_READY;
        else         state_q <= state_d;
    end

    assign init_last = (init_cnt_q == WIDX_W'(DEPTH - 1));

    //--------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_last) state_d = S_READY;
            S_READY: state_d = S_READY;
            default: state_d = S_READY;
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        init_wr   = 1'b0;
        case (state_q)
            S_INIT:  init_wr   = 1'b1;
            S_READY: req_ready = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Init sequencer: one word cleared per cycle, DEPTH cycles total.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            init_cnt_q  <= '0;
            init_done_q <= (INIT_CLEAR == 0);
        end else if (state_q == S_INIT) begin
            init_cnt_q <= init_cnt_q + WIDX_W'(1);
            if (init_last) init_done_q <= 1'b1;
        end
    end

    //--------------------------------------------------------------------
    // Request decode
    //--------------------------------------------------------------------
    assign accept = bus.req_valid & req_ready;
    assign off    = bus.req_addr[OFF-1:0];
    assign widx   = bus.req_addr[ADDR_W-1:OFF];
    assign nbytes = 4'd1 << bus.req_size;

    // Misaligned when the offset is not a multiple of the access size;
    // dword is only meaningful on a 64-bit word.
    assign req_err = ((4'(off) & (nbytes - 4'd1)) != 4'd0) ||
                     ((bus.req_size == 2'd3) && (LANES < 8));

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LANES; k++)
            lane_mask[k] = (k >= int'(off)) && (k < int'(off) + int'(nbytes));
    end

    // Lane k takes store byte (k-off).
    assign wdata_sh = bus.req_wdata << {off, 3'b000};

    always_comb begin
        lane_we    = '0;
        lane_re    = 1'b0;
        lane_addr  = widx;
        lane_wdata = wdata_sh;
        if (init_wr) begin
            lane_we    = '1;
            lane_addr  = init_cnt_q;
            lane_wdata = '0;
        end else if (accept && rst_ni && !req_err) begin
            if (bus.req_we) lane_we = lane_mask;
            else            lane_re = 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        riscv_data_ram_lane #(
            .DEPTH (DEPTH),
            .AW    (WIDX_W)
        ) u_lane (
            .clk_i   (clk_i),
            .we_i    (lane_we[g]),
            .re_i    (lane_re),
            .addr_i  (lane_addr),
            .wdata_i (lane_wdata[g]),
            .rdata_o (lane_rdata[g])
        );
    end

    //--------------------------------------------------------------------
    // Response stage
    //--------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_err_q  <= req_err;
                rsp_load_q <= ~bus.req_we;
                off_q      <= off;
                size_q     <= bus.req_size;
                uns_q      <= bus.req_unsigned;
            end
        end
    end

    assign rd_sh = lane_rdata >> {off_q, 3'b000};

    // Keep the low 8*2^size bits, fill the rest with the sign (or zero).
    always_comb begin
        int  nb;
        logic sgn;
        nb     = 8 << size_q;
        sgn    = 1'b0;
        rd_ext = '0;
        for (int i = 0; i < DATA_W; i++)
            if (i == nb - 1) sgn = rd_sh[i];
        sgn = sgn & ~uns_q;
        for (int i = 0; i < DATA_W; i++)
            rd_ext[i] = (i < nb) ? rd_sh[i] : sgn;
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_load_q && !rsp_err_q) ? rd_ext : '0;
    assign init_done_o   = init_done_q;
endmodule

// File: tb/tb_riscv_data_ram.sv
module tb_riscv_data_ram;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  mdl [1024];
    logic [31:0] last_d = '0;
    logic        last_e = 1'b0;
    logic [31:0] obs_d;

    riscv_data_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    riscv_data_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_CLEAR(1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .init_done_o (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Byte-addressed reference memory.
    function automatic logic mdl_err(input logic [9:0] a, input logic [1:0] s);
        int n = 1 << s;
        return (s == 2'd3) || ((int'(a) % n) != 0);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [9:0] a, input logic [1:0] s, input logic u);
        int n = 1 << s;
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v |= 64'(mdl[int'(a) + i]) << (8 * i);
        if (!u && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
    endtask

    task automatic idle_bus();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_size = 2'd0; bus.req_unsigned = 1'b0; bus.req_wdata = '0;
    endtask

    // One clock cycle: present (optionally) a request, check its response.
    task automatic step(input logic v, input logic we, input logic [9:0] a,
                        input logic [1:0] s, input logic u, input logic [31:0] wd);
        logic e;
        logic [31:0] exp_d;
        bus.req_valid = v; bus.req_we = we; bus.req_addr = a;
        bus.req_size = s; bus.req_unsigned = u; bus.req_wdata = wd;
        e = mdl_err(a, s);
        exp_d = '0;
        if (v && !e) begin
            if (we) begin
                for (int i = 0; i < (1 << s); i++) mdl[int'(a) + i] = wd[8*i +: 8];
            end else begin
                exp_d = mdl_load(a, s, u);
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        obs_d = bus.rsp_rdata;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(v));
        if (v) begin
            last_d = exp_d;
            last_e = e;
        end
        chk(v ? "rsp_err" : "rsp_err_hold", 64'(bus.rsp_err), 64'(last_e));
        chk(v ? "rsp_rdata" : "rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(last_d));
    endtask

    // Count cycles from reset release to init_done, with a store presented
    // throughout that must be ignored.
    task automatic wait_init(input string tag);
        int cyc = 0;
        logic bad = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 10'h010;
        bus.req_size = 2'd2; bus.req_wdata = 32'hFFFF_FFFF;
        while (!init_done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rsp_valid || (!init_done && bus.req_ready)) bad = 1'b1;
        end
        idle_bus();
        chk({tag, "_cycles"}, 64'(cyc), 64'(DEPTH));
        chk({tag, "_ready_low"}, 64'(bad), 64'd0);
        chk({tag, "_ready_after"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        idle_bus();
        mdl_clear();

        // 1: reset state, init length, cleared memory
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        rst_n = 1'b1;
        wait_init("init1");
        step(1, 0, 10'h3FC, 2'd2, 0, 0);
        chk("t1_load_3fc", 64'(obs_d), 64'h0);
        step(1, 0, 10'h010, 2'd2, 0, 0);
        chk("t1_ignored_store", 64'(obs_d), 64'h0);

        // 2: word store, sub-word loads
        step(1, 1, 10'h010, 2'd2, 0, 32'h1234_5678);
        step(1, 0, 10'h011, 2'd0, 1, 0);
        chk("t2_lbu_011", 64'(obs_d), 64'h56);
        step(1, 0, 10'h013, 2'd0, 0, 0);
        chk("t2_lb_013", 64'(obs_d), 64'h12);
        step(1, 0, 10'h012, 2'd1, 0, 0);
        chk("t2_lh_012", 64'(obs_d), 64'h1234);

        // 3: byte merge, sign/zero extension
        step(1, 1, 10'h020, 2'd2, 0, 32'h1122_3344);
        step(1, 1, 10'h022, 2'd0, 0, 32'h0000_00AB);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 10'h020, 2'd2, 0, 0);
        chk("t3_lw_020", 64'(obs_d), 64'h11AB_3344);
        step(1, 0, 10'h022, 2'd0, 0, 0);
        chk("t3_lb_022", 64'(obs_d), 64'hFFFF_FFAB);
        step(1, 0, 10'h022, 2'd1, 1, 0);
        chk("t3_lhu_022", 64'(obs_d), 64'h11AB);

        // 4: errors
        step(1, 1, 10'h030, 2'd2, 0, 32'hCAFE_F00D);
        step(1, 1, 10'h031, 2'd1, 0, 32'h0000_BEEF);
        chk("t4_sh_031_err", 64'(bus.rsp_err), 64'd1);
        chk("t4_sh_031_rdata", 64'(obs_d), 64'h0);
        step(1, 0, 10'h030, 2'd2, 0, 0);
        chk("t4_lw_030", 64'(obs_d), 64'hCAFE_F00D);
        step(1, 0, 10'h002, 2'd2, 0, 0);
        chk("t4_lw_002_err", 64'(bus.rsp_err), 64'd1);
        step(1, 0, 10'h000, 2'd3, 0, 0);
        chk("t4_size3_err", 64'(bus.rsp_err), 64'd1);
        step(1, 1, 10'h018, 2'd3, 0, 32'h5555_5555);
        chk("t4_size3_st_err", 64'(bus.rsp_err), 64'd1);
        step(1, 0, 10'h018, 2'd2, 0, 0);
        chk("t4_size3_no_write", 64'(obs_d), 64'h0);

        // 5: back-to-back store then load
        step(1, 1, 10'h040, 2'd2, 0, 32'hDEAD_BEEF);
        step(1, 0, 10'h040, 2'd2, 0, 0);
        chk("t5_b2b_lw", 64'(obs_d), 64'hDEAD_BEEF);

        // Randomized traffic with bubbles, checked against the byte model.
        for (int r = 0; r < 400; r++) begin
            logic       v, we, u;
            logic [1:0] s;
            logic [9:0] a;
            v  = ($urandom_range(0, 4) != 0);
            we = $urandom_range(0, 1) != 0;
            u  = $urandom_range(0, 1) != 0;
            s  = 2'($urandom_range(0, 3));
            a  = 10'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~10'((1 << s) - 1);
            step(v, we, a, s, u, $urandom);
        end

        // 6: reset with a load presented, then mid-INIT reset
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h040;
        bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        idle_bus();
        chk("t6_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("t6_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("t6_rst_init_done", 64'(init_done), 64'd0);
        chk("t6_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("t6_mid_init_done", 64'(init_done), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init("init2");
        mdl_clear();
        step(1, 0, 10'h040, 2'd2, 0, 0);
        chk("t6_cleared_040", 64'(obs_d), 64'h0);
        step(1, 0, 10'h3FC, 2'd2, 0, 0);
        chk("t6_cleared_3fc", 64'(obs_d), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
